div_seq_unit: RTL and testbench

DIV_SEQ_UNIT -- requirements
Module: div_seq_unit

---
 rtl/div_seq_unit.sv | 138 +++++++++++++
 tb/tb_div_seq_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq_unit.sv
// Sequential restoring divider: one quotient bit per cycle, RISC-V DIVU/REMU
// semantics for a zero divisor (all-ones quotient, remainder = dividend).
module div_seq_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             valid_o,
    output logic             dbz_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] reminder_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   work_q, work_d;   // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]   dsr_q, dsr_d;     // latched divisor
    logic [WIDTH-1:0]   rem_q, rem_d;     // partial remainder
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               valid_q, valid_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   reminder_q, reminder_d;

    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     diff;

    // Next-state, datapath step and output register inputs
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        dsr_d      = dsr_q;
        rem_d      = rem_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        valid_d    = valid_q;
        dbz_d      = dbz_q;
        quotient_d = quotient_q;
        reminder_d = reminder_q;

        // Partial remainder is always < divisor, so a borrow shows up in bit WIDTH.
        rem_shift  = {rem_q, work_q[WIDTH-1]};
        diff       = rem_shift - {1'b0, dsr_q};

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    valid_d = 1'b0;
                    dbz_d   = 1'b0;
                    if (divisor_i == '0) begin
                        quotient_d = '1;
                        reminder_d = dividend_i;
                        dbz_d      = 1'b1;
                        valid_d    = 1'b1;
                        done_d     = 1'b1;
                    end else begin
                        state_d = CALC;
                        busy_d  = 1'b1;
                        work_d  = dividend_i;
                        dsr_d   = divisor_i;
                        rem_d   = '0;
                        cnt_d   = '0;
                    end
                end
            end
            CALC: begin
                if (diff[WIDTH]) begin
                    rem_d = rem_shift[WIDTH-1:0];
                end else begin
                    rem_d = diff[WIDTH-1:0];
                end
                work_d = {work_q[WIDTH-2:0], ~diff[WIDTH]};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d    = IDLE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    valid_d    = 1'b1;
                    dbz_d      = 1'b0;
                    cnt_d      = '0;
                    quotient_d = work_d;
                    reminder_d = rem_d;
                end
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            work_q     <= '0;
            dsr_q      <= '0;
            rem_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            dbz_q      <= 1'b0;
            quotient_q <= '0;
            reminder_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            dsr_q      <= dsr_d;
            rem_q      <= rem_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
            dbz_q      <= dbz_d;
            quotient_q <= quotient_d;
            reminder_q <= reminder_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign valid_o    = valid_q;
    assign dbz_o      = dbz_q;
    assign quotient_o = quotient_q;
    assign reminder_o = reminder_q;

endmodule

// File: tb/tb_div_seq_unit.sv
// Self-checking bench for div_seq_unit against a plain-arithmetic divide model.
`timescale 1ns/1ps
module tb_div_seq_unit;

    localparam int unsigned WIDTH = 32;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             start_i;
    logic [WIDTH-1:0] dividend_i;
    logic [WIDTH-1:0] divisor_i;
    logic             busy_o;
    logic             done_o;
    logic             valid_o;
    logic             dbz_o;
    logic [WIDTH-1:0] quotient_o;
    logic [WIDTH-1:0] reminder_o;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] prev_q = '0;
    logic [WIDTH-1:0] prev_r = '0;

    div_seq_unit #(.WIDTH(WIDTH)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .valid_o    (valid_o),
        .dbz_o      (dbz_o),
        .quotient_o (quotient_o),
        .reminder_o (reminder_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One division from start to completion; noise pokes start/operands during CALC.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit noise);
        logic [WIDTH-1:0] eq, er;
        int busy_cnt, done_cnt;
        if (b == '0) begin
            eq = '1;
            er = a;
        end else begin
            eq = a / b;
            er = a % b;
        end
        start_i = 1'b1; dividend_i = a; divisor_i = b;
        tick();
        start_i = 1'b0; dividend_i = $urandom; divisor_i = $urandom;
        if (b == '0) begin
            checks++;
            if ({busy_o, done_o, valid_o, dbz_o} !== 4'b0111) begin
                failures++;
                $display("FAIL dbz_status a=%h: busy/done/valid/dbz got %b want 0111", a, {busy_o, done_o, valid_o, dbz_o});
            end
            checks++;
            if ({quotient_o, reminder_o} !== {eq, er}) begin
                failures++;
                $display("FAIL dbz_result a=%h: got q=%h r=%h want q=%h r=%h", a, quotient_o, reminder_o, eq, er);
            end
        end else begin
            checks++;
            if ({busy_o, done_o, valid_o, dbz_o} !== 4'b1000) begin
                failures++;
                $display("FAIL start_status %h/%h: busy/done/valid/dbz got %b want 1000", a, b, {busy_o, done_o, valid_o, dbz_o});
            end
            busy_cnt = 1;
            done_cnt = 0;
            while (busy_o === 1'b1 && busy_cnt <= 2 * WIDTH) begin
                checks++;
                if (valid_o !== 1'b0 || quotient_o !== prev_q || reminder_o !== prev_r) begin
                    failures++;
                    $display("FAIL calc_hold %h/%h: valid=%b q=%h r=%h want valid=0 q=%h r=%h", a, b, valid_o, quotient_o, reminder_o, prev_q, prev_r);
                end
                if (noise) begin
                    start_i    = 1'($urandom_range(0, 1));
                    dividend_i = $urandom;
                    divisor_i  = $urandom;
                end
                tick();
                if (done_o === 1'b1) done_cnt++;
                if (busy_o === 1'b1) busy_cnt++;
            end
            start_i = 1'b0;
            checks++;
            if (busy_cnt != WIDTH) begin
                failures++;
                $display("FAIL busy_len %h/%h: got %0d cycles want %0d", a, b, busy_cnt, WIDTH);
            end
            checks++;
            if ({busy_o, done_o, valid_o, dbz_o} !== 4'b0110 || done_cnt != 1) begin
                failures++;
                $display("FAIL done_status %h/%h: busy/done/valid/dbz got %b pulses=%0d want 0110 pulses=1", a, b, {busy_o, done_o, valid_o, dbz_o}, done_cnt);
            end
            checks++;
            if ({quotient_o, reminder_o} !== {eq, er}) begin
                failures++;
                $display("FAIL result %h/%h: got q=%h r=%h want q=%h r=%h", a, b, quotient_o, reminder_o, eq, er);
            end
        end
        prev_q = eq;
        prev_r = er;
    endtask

    // Idle cycle after completion: done drops, result stays valid and held.
    task automatic check_idle_hold(input string tag);
        tick();
        checks++;
        if ({busy_o, done_o, valid_o} !== 3'b001 || quotient_o !== prev_q || reminder_o !== prev_r) begin
            failures++;
            $display("FAIL %s: busy/done/valid=%b q=%h r=%h want 001 q=%h r=%h", tag, {busy_o, done_o, valid_o}, quotient_o, reminder_o, prev_q, prev_r);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; start_i = 1'b1; dividend_i = 32'd77; divisor_i = 32'd0;
        repeat (3) tick();
        checks++;
        if ({busy_o, done_o, valid_o, dbz_o, quotient_o, reminder_o} !== '0) begin
            failures++;
            $display("FAIL reset_state: busy/done/valid/dbz=%b q=%h r=%h want all 0", {busy_o, done_o, valid_o, dbz_o}, quotient_o, reminder_o);
        end
        start_i = 1'b0;
        rst_ni  = 1'b1;
        tick();
        prev_q = '0;
        prev_r = '0;
    endtask

    task automatic test_basic();
        run_op(32'd100, 32'd7, 1'b0);
        check_idle_hold("basic_hold");
    endtask

    task automatic test_div_by_zero();
        run_op(32'h0000_1234, 32'd0, 1'b0);
        check_idle_hold("dbz_hold");
        checks++;
        if (dbz_o !== 1'b1) begin
            failures++;
            $display("FAIL dbz_held: dbz=%b want 1", dbz_o);
        end
    endtask

    task automatic test_edge_values();
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0);
        run_op(32'h0000_0005, 32'hFFFF_FFFF, 1'b0);
        run_op(32'd0, 32'd9, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(32'h8000_0000, 32'h8000_0001, 1'b0);
    endtask

    task automatic test_ignore_start();
        run_op(32'd1000, 32'd10, 1'b1);
        check_idle_hold("ignore_start_hold");
    endtask

    task automatic test_reset_abort();
        int stray;
        start_i = 1'b1; dividend_i = 32'd1000; divisor_i = 32'd10;
        tick();
        start_i = 1'b0;
        repeat (9) tick();
        rst_ni = 1'b0; start_i = 1'b1;
        tick();
        checks++;
        if ({busy_o, done_o, valid_o, dbz_o, quotient_o, reminder_o} !== '0) begin
            failures++;
            $display("FAIL abort_state: busy/done/valid/dbz=%b q=%h r=%h want all 0", {busy_o, done_o, valid_o, dbz_o}, quotient_o, reminder_o);
        end
        start_i = 1'b0;
        rst_ni  = 1'b1;
        prev_q  = '0;
        prev_r  = '0;
        stray   = 0;
        repeat (2 * WIDTH) begin
            tick();
            if (done_o !== 1'b0 || busy_o !== 1'b0 || valid_o !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL abort_quiet: %0d active cycles after abort want 0", stray);
        end
        run_op(32'd15, 32'd4, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_op(32'd50, 32'd7, 1'b0);
        run_op(32'd20, 32'd6, 1'b0);
        run_op(32'd9, 32'd0, 1'b0);
        run_op(32'd7, 32'd0, 1'b0);
        run_op(32'd7, 32'd2, 1'b0);
        check_idle_hold("b2b_hold");
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] a, b;
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 4))
                0: b = '0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'($urandom) >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 100)) : 32'($urandom);
            run_op(a, b, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) check_idle_hold("rand_hold");
        end
    endtask

    initial begin
        rst_ni = 1'b0; start_i = 1'b0; dividend_i = '0; divisor_i = '0;
        test_reset();
        test_basic();
        test_div_by_zero();
        test_edge_values();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
